// File: rtl/ram_sched_if.sv
// Bundle between ram_sched and its three requesters plus the single 8-bit RAM port.
// slave is the scheduler side; master is the requester/RAM side.
interface ram_sched_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_discard;
   logic              if_ready;
   logic [31:0]       if_data;

   logic              ld_req;
   logic [ADDR_W-1:0] ld_addr;
   logic [2:0]        ld_len;
   logic              ld_signed;
   logic              ld_ready;
   logic [31:0]       ld_data;

   logic              st_req;
   logic [ADDR_W-1:0] st_addr;
   logic [2:0]        st_len;
   logic [31:0]       st_data;
   logic              st_done;

   logic              busy;
   logic              ram_rw;
   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_w_data;
   logic [7:0]        ram_r_data;

   modport slave (
      input  if_req, if_addr, if_discard,
      output if_ready, if_data,
      input  ld_req, ld_addr, ld_len, ld_signed,
      output ld_ready, ld_data,
      input  st_req, st_addr, st_len, st_data,
      output st_done,
      output busy, ram_rw, ram_addr, ram_w_data,
      input  ram_r_data
   );

   modport master (
      output if_req, if_addr, if_discard,
      input  if_ready, if_data,
      output ld_req, ld_addr, ld_len, ld_signed,
      input  ld_ready, ld_data,
      output st_req, st_addr, st_len, st_data,
      input  st_done,
      input  busy, ram_rw, ram_addr, ram_w_data,
      output ram_r_data
   );
endinterface

// File: rtl/ram_sched.sv
// Byte-serial scheduler sharing one 8-bit RAM port between fetch, load and store.
// Fixed priority ld > if > st, with a store override once it has lost STARVE_LIMIT times.
module ram_sched #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic        clock,
   input logic        reset,
   ram_sched_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StLoad, StFetch, StStore} state_e;

   function automatic logic [2:0] eff_len(input logic [2:0] len);
      return (len == 3'd1 || len == 3'd2) ? len : 3'd4;
   endfunction

   state_e            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d, len_q, len_d;
   logic [3:0]        starve_q, starve_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic              sgn_q, sgn_d;
   logic [31:0]       wdata_q, wdata_d, buf_q, buf_d;
   logic [31:0]       if_data_q, if_data_d, ld_data_q, ld_data_d;
   logic              if_ready_q, if_ready_d, ld_ready_q, ld_ready_d, st_done_q, st_done_d;

   logic              ld_ok, if_ok, st_ok, st_first, gnt_ld, gnt_if, gnt_st;
   logic              rw_c;
   logic [ADDR_W-1:0] addr_c;
   logic [7:0]        wbyte_c;
   logic [1:0]        rd_idx;
   logic [2:0]        st_len_eff;

   // A requester whose pulse is high still holds its request; it must not win again.
   assign ld_ok      = bus.ld_req & ~ld_ready_q;
   assign if_ok      = bus.if_req & ~bus.if_discard & ~if_ready_q;
   assign st_ok      = bus.st_req & ~st_done_q;
   assign st_first   = st_ok & (starve_q >= 4'(STARVE_LIMIT));
   assign gnt_st     = st_first | (st_ok & ~ld_ok & ~if_ok);
   assign gnt_ld     = ld_ok & ~st_first;
   assign gnt_if     = if_ok & ~ld_ok & ~st_first;
   assign rd_idx     = 2'(cnt_q - 3'd1);
   assign st_len_eff = eff_len(bus.st_len);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      starve_d   = starve_q;
      base_d     = base_q;
      sgn_d      = sgn_q;
      wdata_d    = wdata_q;
      buf_d      = buf_q;
      if_data_d  = if_data_q;
      ld_data_d  = ld_data_q;
      if_ready_d = 1'b0;
      ld_ready_d = 1'b0;
      st_done_d  = 1'b0;
      rw_c       = 1'b0;
      addr_c     = '0;
      wbyte_c    = '0;
      unique case (state_q)
         StIdle: begin
            if (gnt_st) begin
               starve_d = '0;
            end else if (st_ok && (gnt_ld || gnt_if) && starve_q != 4'hF) begin
               starve_d = starve_q + 4'd1;
            end
            if (gnt_ld) begin
               addr_c  = bus.ld_addr;
               base_d  = bus.ld_addr;
               len_d   = eff_len(bus.ld_len);
               sgn_d   = bus.ld_signed;
               buf_d   = '0;
               cnt_d   = 3'd1;
               state_d = StLoad;
            end else if (gnt_if) begin
               addr_c  = bus.if_addr;
               base_d  = bus.if_addr;
               len_d   = 3'd4;
               buf_d   = '0;
               cnt_d   = 3'd1;
               state_d = StFetch;
            end else if (gnt_st) begin
               rw_c    = 1'b1;
               addr_c  = bus.st_addr;
               wbyte_c = bus.st_data[7:0];
               base_d  = bus.st_addr;
               len_d   = st_len_eff;
               wdata_d = bus.st_data;
               cnt_d   = 3'd1;
               if (st_len_eff == 3'd1) st_done_d = 1'b1;
               else                    state_d   = StStore;
            end
         end
         StLoad, StFetch: begin
            addr_c = base_q + ADDR_W'(cnt_q);
            // ram_r_data now carries byte cnt-1, addressed in the previous cycle.
            buf_d[{rd_idx, 3'b000} +: 8] = bus.ram_r_data;
            if (state_q == StFetch && bus.if_discard) begin
               state_d = StIdle;
            end else if (cnt_q == len_q) begin
               state_d = StIdle;
               if (state_q == StFetch) begin
                  if_ready_d = 1'b1;
                  if_data_d  = buf_d;
               end else begin
                  ld_ready_d = 1'b1;
                  unique case (len_q)
                     3'd1:    ld_data_d = {{24{sgn_q & buf_d[7]}}, buf_d[7:0]};
                     3'd2:    ld_data_d = {{16{sgn_q & buf_d[15]}}, buf_d[15:0]};
                     default: ld_data_d = buf_d;
                  endcase
               end
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         StStore: begin
            rw_c    = 1'b1;
            addr_c  = base_q + ADDR_W'(cnt_q);
            wbyte_c = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
            if (cnt_q == len_q - 3'd1) begin
               state_d   = StIdle;
               st_done_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         len_q      <= '0;
         starve_q   <= '0;
         base_q     <= '0;
         sgn_q      <= 1'b0;
         wdata_q    <= '0;
         buf_q      <= '0;
         if_data_q  <= '0;
         ld_data_q  <= '0;
         if_ready_q <= 1'b0;
         ld_ready_q <= 1'b0;
         st_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         starve_q   <= starve_d;
         base_q     <= base_d;
         sgn_q      <= sgn_d;
         wdata_q    <= wdata_d;
         buf_q      <= buf_d;
         if_data_q  <= if_data_d;
         ld_data_q  <= ld_data_d;
         if_ready_q <= if_ready_d;
         ld_ready_q <= ld_ready_d;
         st_done_q  <= st_done_d;
      end
   end

   assign bus.if_ready   = if_ready_q;
   assign bus.if_data    = if_data_q;
   assign bus.ld_ready   = ld_ready_q;
   assign bus.ld_data    = ld_data_q;
   assign bus.st_done    = st_done_q;
   assign bus.busy       = (state_q != StIdle);
   assign bus.ram_rw     = rw_c & reset;
   assign bus.ram_addr   = addr_c;
   assign bus.ram_w_data = wbyte_c;

endmodule

// File: tb/tb_ram_sched.sv
// Bench for ram_sched: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the scheduler.
module tb_ram_sched;

   localparam int unsigned AW    = 32;
   localparam int unsigned LIMIT = 4;
   localparam int          NTX   = 30;

   bit clk = 1'b0;
   bit rst_n;
   always #5 clk = ~clk;

   ram_sched_if #(.ADDR_W(AW)) bus ();

   ram_sched #(.ADDR_W(AW), .STARVE_LIMIT(LIMIT)) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int passed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // ---------------- RAM: 1 KiB, indexed by the low 10 address bits ----------------
   logic [7:0] mem [0:1023];
   bit         mem_ready = 1'b0;

   function automatic logic [7:0] init_byte(input int i);
      case (i)
         32'h100: return 8'h11;
         32'h101: return 8'h22;
         32'h102: return 8'h33;
         32'h103: return 8'h44;
         32'h180: return 8'h80;
         default: return 8'(i * 37 + 5);
      endcase
   endfunction

   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 1024; i++) mem[i] <= init_byte(i);
         mem_ready <= 1'b1;
      end else if (bus.ram_rw) begin
         mem[bus.ram_addr[9:0]] <= bus.ram_w_data;
      end
      bus.ram_r_data <= mem[bus.ram_addr[9:0]];
   end

   // ---------------- Transaction-level reference model ----------------
   function automatic int eff(input logic [2:0] l);
      return (l == 3'd1) ? 1 : (l == 3'd2) ? 2 : 4;
   endfunction

   // Little-endian word of n bytes at a, extended from the top byte when sgn.
   function automatic logic [31:0] rd_word(input logic [31:0] a, input int n, input bit sgn);
      logic [31:0] w, ak;
      w = '0;
      for (int k = 0; k < 4; k++) begin
         ak = a + k;
         if (k < n) w[8*k +: 8] = mem[ak[9:0]];
         else       w[8*k +: 8] = (sgn && w[8*n-1]) ? 8'hFF : 8'h00;
      end
      return w;
   endfunction

   bit          mv = 1'b0;
   int          m_kind;  // 0 none, 1 load, 2 fetch, 3 store
   int          m_phase, m_n, m_starve, win;
   logic [31:0] m_base, m_sdata, m_res;
   bit          e_ifr, e_ldr, e_std, ld_ok, if_ok, st_ok;
   logic [31:0] e_ifd, e_ldd;
   logic        x_rw;
   logic [31:0] x_addr;
   logic [7:0]  x_wd;
   bit          x_chk_addr;

   always @(negedge clk) begin
      win = 0;
      if (mv) begin
         chk("if_ready", bus.if_ready, e_ifr);
         chk("ld_ready", bus.ld_ready, e_ldr);
         chk("st_done", bus.st_done, e_std);
         chk("busy", bus.busy, m_kind != 0);
         if (e_ifr) chk("if_data", bus.if_data, e_ifd);
         if (e_ldr) chk("ld_data", bus.ld_data, e_ldd);
         x_rw = 1'b0; x_addr = '0; x_wd = '0; x_chk_addr = 1'b1;
         ld_ok = bus.ld_req && !e_ldr;
         if_ok = bus.if_req && !bus.if_discard && !e_ifr;
         st_ok = bus.st_req && !e_std;
         if (m_kind == 0) begin
            if (st_ok && m_starve >= LIMIT) win = 3;
            else if (ld_ok)                 win = 1;
            else if (if_ok)                 win = 2;
            else if (st_ok)                 win = 3;
            if (win == 1) x_addr = bus.ld_addr;
            if (win == 2) x_addr = bus.if_addr;
            if (win == 3) begin
               x_rw = 1'b1; x_addr = bus.st_addr; x_wd = bus.st_data[7:0];
            end
         end else if (m_kind == 3) begin
            x_rw = 1'b1; x_addr = m_base + m_phase; x_wd = 8'(m_sdata >> (8 * m_phase));
         end else begin
            x_addr = m_base + m_phase;
            x_chk_addr = (m_phase < m_n);
         end
         if (!rst_n) begin
            x_rw = 1'b0; x_chk_addr = 1'b0;
         end
         chk("ram_rw", bus.ram_rw, x_rw);
         if (x_chk_addr) chk("ram_addr", bus.ram_addr, x_addr);
         if (x_rw) chk("ram_w_data", bus.ram_w_data, x_wd);
      end
      if (!rst_n) begin
         mv = 1'b1; m_kind = 0; m_starve = 0; m_phase = 0; m_n = 0;
         e_ifr = 0; e_ldr = 0; e_std = 0; e_ifd = '0; e_ldd = '0;
      end else if (mv) begin
         e_ifr = 0; e_ldr = 0; e_std = 0;
         if (m_kind == 0) begin
            if (win == 3) m_starve = 0;
            else if (win != 0 && st_ok && m_starve < 15) m_starve++;
            m_phase = 1;
            if (win == 1) begin
               m_kind = 1; m_n = eff(bus.ld_len); m_base = bus.ld_addr;
               m_res = rd_word(bus.ld_addr, m_n, bus.ld_signed);
            end else if (win == 2) begin
               m_kind = 2; m_n = 4; m_base = bus.if_addr;
               m_res = rd_word(bus.if_addr, 4, 1'b0);
            end else if (win == 3) begin
               m_n = eff(bus.st_len); m_base = bus.st_addr; m_sdata = bus.st_data;
               if (m_n == 1) e_std = 1;
               else          m_kind = 3;
            end
         end else if (m_kind == 2 && bus.if_discard) begin
            m_kind = 0;
         end else if (m_kind == 3) begin
            if (m_phase == m_n - 1) begin e_std = 1; m_kind = 0; end
            else m_phase++;
         end else if (m_phase == m_n) begin
            if (m_kind == 1) begin e_ldr = 1; e_ldd = m_res; end
            else             begin e_ifr = 1; e_ifd = m_res; end
            m_kind = 0;
         end else begin
            m_phase++;
         end
      end
   end

   // ---------------- Stimulus helpers ----------------
   function automatic logic [31:0] rnd_addr();
      if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF8 + $urandom_range(0, 7);
      return $urandom_range(0, 32'h1F0);
   endfunction

   task automatic run_load(input logic [31:0] a, input logic [2:0] len, input bit sgn,
                           output int lat, output logic [31:0] d);
      bus.ld_req = 1'b1; bus.ld_addr = a; bus.ld_len = len; bus.ld_signed = sgn;
      lat = -1; d = '0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.ld_ready) begin lat = c; d = bus.ld_data; break; end
         tick();
      end
      tick();
      bus.ld_req = 1'b0;
   endtask

   task automatic drv_load;
      bit got;
      for (int t = 0; t < NTX; t++) begin
         repeat ($urandom_range(0, 3)) tick();
         bus.ld_addr = rnd_addr(); bus.ld_len = 3'($urandom_range(0, 7));
         bus.ld_signed = 1'($urandom_range(0, 1)); bus.ld_req = 1'b1;
         got = 0;
         for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.ld_ready) begin got = 1; break; end
            tick();
         end
         chk("ld_wait", got, 1'b1);
         tick();
         bus.ld_req = 1'b0;
      end
   endtask

   task automatic drv_fetch;
      bit got, aborted;
      for (int t = 0; t < NTX; t++) begin
         repeat ($urandom_range(0, 3)) tick();
         bus.if_addr = rnd_addr(); bus.if_req = 1'b1;
         got = 0; aborted = 0;
         for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.if_ready) begin got = 1; break; end
            if ($urandom_range(0, 15) == 0) begin
               tick(); bus.if_discard = 1'b1; bus.if_req = 1'b0;
               tick(); bus.if_discard = 1'b0;
               got = 1; aborted = 1;
               break;
            end
            tick();
         end
         chk("if_wait", got, 1'b1);
         if (!aborted) begin
            tick();
            bus.if_req = 1'b0;
         end
      end
   endtask

   task automatic drv_store;
      bit got;
      for (int t = 0; t < NTX; t++) begin
         repeat ($urandom_range(0, 3)) tick();
         bus.st_addr = rnd_addr(); bus.st_len = 3'($urandom_range(0, 7));
         bus.st_data = $urandom; bus.st_req = 1'b1;
         got = 0;
         for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.st_done) begin got = 1; break; end
            tick();
         end
         chk("st_wait", got, 1'b1);
         tick();
         bus.st_req = 1'b0;
      end
   endtask

   // ---------------- Main sequence ----------------
   int          lat, rl, ri, nl, ni, cnt;
   bit          sd, bb;
   logic [31:0] d;

   initial begin
      rst_n = 1'b0;
      bus.if_req = 0; bus.if_addr = '0; bus.if_discard = 0;
      bus.ld_req = 0; bus.ld_addr = '0; bus.ld_len = '0; bus.ld_signed = 0;
      bus.st_req = 0; bus.st_addr = '0; bus.st_len = '0; bus.st_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_if_ready", bus.if_ready, 1'b0);
      chk("rst_ld_ready", bus.ld_ready, 1'b0);
      chk("rst_st_done", bus.st_done, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_if_data", bus.if_data, 32'h0);
      chk("rst_ld_data", bus.ld_data, 32'h0);
      tick();
      rst_n = 1'b1;
      repeat (2) tick();

      run_load(32'h100, 3'd4, 1'b0, lat, d);
      chk("ld4_latency", lat, 5);
      chk("ld4_data", d, 32'h4433_2211);
      repeat (2) tick();
      run_load(32'h180, 3'd1, 1'b1, lat, d);
      chk("ld1s_latency", lat, 2);
      chk("ld1s_data", d, 32'hFFFF_FF80);
      repeat (2) tick();
      run_load(32'h180, 3'd1, 1'b0, lat, d);
      chk("ld1u_data", d, 32'h0000_0080);
      repeat (2) tick();

      // Load and fetch raised together: fetch wins in the ld_ready cycle.
      bus.ld_req = 1; bus.ld_addr = 32'h100; bus.ld_len = 3'd2; bus.ld_signed = 0;
      bus.if_req = 1; bus.if_addr = 32'h104;
      rl = -1; ri = -1; bb = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (rl >= 0 && c == rl + 1) bb = bus.busy;
         if (bus.ld_ready && rl < 0) rl = c;
         if (bus.if_ready) begin ri = c; break; end
         tick();
         if (rl >= 0) bus.ld_req = 0;
      end
      tick();
      bus.if_req = 0; bus.ld_req = 0;
      chk("ldif_ld_latency", rl, 3);
      chk("ldif_if_gap", ri - rl, 5);
      chk("ldif_busy_after", bb, 1'b1);
      repeat (3) tick();

      // Starvation: st pending behind held ld/if until it has lost LIMIT times.
      bus.st_req = 1; bus.st_addr = 32'h1C0; bus.st_len = 3'd1; bus.st_data = 32'h5A;
      bus.if_req = 1; bus.if_addr = 32'h0;
      bus.ld_req = 1; bus.ld_addr = 32'h10; bus.ld_len = 3'd1;
      nl = 0; ni = 0; sd = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (bus.ld_ready) nl++;
         if (bus.if_ready) ni++;
         if (bus.st_done) begin sd = 1; break; end
         tick();
      end
      tick();
      bus.st_req = 0; bus.if_req = 0; bus.ld_req = 0;
      chk("starve_done", sd, 1'b1);
      chk("starve_loads_first", nl, 2);
      chk("starve_fetches_first", ni, 2);
      repeat (12) tick();

      // Two-byte store wrapping past the top of the address space.
      bus.st_req = 1; bus.st_addr = 32'hFFFF_FFFF; bus.st_len = 3'd2; bus.st_data = 32'h0000_BEEF;
      lat = -1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.st_done) begin lat = c; break; end
         tick();
      end
      tick();
      bus.st_req = 0;
      chk("st2_latency", lat, 2);
      chk("st2_mem_top", mem[10'h3FF], 8'hEF);
      chk("st2_mem_zero", mem[10'h000], 8'hBE);
      repeat (2) tick();

      // Fetch aborted in FETCH cycle 2.
      bus.if_req = 1; bus.if_addr = 32'h20;
      tick();
      tick();
      bus.if_discard = 1; bus.if_req = 0;
      @(negedge clk);
      chk("abort_busy_c2", bus.busy, 1'b1);
      tick();
      bus.if_discard = 0;
      @(negedge clk);
      chk("abort_idle_c3", bus.busy, 1'b0);
      cnt = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus.if_ready) cnt++;
         tick();
      end
      chk("abort_no_ready", cnt, 0);

      // Reset lands in STORE cycle 1.
      bus.st_req = 1; bus.st_addr = 32'h1E0; bus.st_len = 3'd4; bus.st_data = 32'hA1B2_C3D4;
      tick();
      rst_n = 0; bus.st_req = 0;
      @(negedge clk);
      chk("rst_store_rw", bus.ram_rw, 1'b0);
      chk("rst_store_busy", bus.busy, 1'b1);
      tick();
      rst_n = 1;
      cnt = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.st_done) cnt++;
         tick();
      end
      chk("rst_store_no_done", cnt, 0);
      chk("rst_store_byte0", mem[10'h1E0], 8'hD4);
      chk("rst_store_byte1", mem[10'h1E1], init_byte(32'h1E1));

      fork
         drv_load();
         drv_fetch();
         drv_store();
      join
      repeat (10) tick();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
